// File: rtl/fifo_fwft_cfg.sv
// First-word-fall-through FIFO with arbitrary depth, runtime almost-full/almost-empty
// thresholds, synchronous flush, sticky overflow/underflow flags and a peak watermark.
module fifo_fwft_cfg #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 18,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    din,
    input  logic                pop,
    output logic [WIDTH-1:0]    dout,
    input  logic                flush,
    input  logic [CNT_BITS-1:0] afull_th,
    input  logic [CNT_BITS-1:0] aempty_th,
    input  logic                err_clr,
    output logic                empty,
    output logic                full,
    output logic                afull,
    output logic                aempty,
    output logic [CNT_BITS-1:0] word_counter,
    output logic                ovf,
    output logic                udf,
    output logic [CNT_BITS-1:0] peak
);
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CNT_BITS-1:0] count_q, count_d, peak_q, peak_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                pop_acc, push_acc, ovf_ev, udf_ev;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign afull        = (count_q >= afull_th);
    assign aempty       = (count_q <= aempty_th);
    assign word_counter = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;
    assign peak         = peak_q;
    assign dout         = mem_q[rp_q];

    always_comb begin
        // Flush suppresses both transfers and both error events.
        pop_acc  = pop & ~empty & ~flush;
        push_acc = push & (~full | pop_acc) & ~flush;
        ovf_ev   = push & full & ~pop_acc & ~flush;
        udf_ev   = pop & empty & ~flush;

        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push_acc) begin
                wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
            end
            if (pop_acc) begin
                rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
            end
            count_d = count_q + CNT_BITS'(push_acc) - CNT_BITS'(pop_acc);
        end

        // An error event in the same cycle as err_clr leaves its flag set.
        ovf_d = ovf_ev | (ovf_q & ~err_clr);
        udf_d = udf_ev | (udf_q & ~err_clr);
        if (err_clr) begin
            peak_d = count_d;
        end else begin
            peak_d = (count_d > peak_q) ? count_d : peak_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            peak_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            peak_q  <= peak_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage has no reset; contents are only observable when non-empty.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wp_q] <= din;
        end
    end
endmodule

// File: tb/tb_fifo_fwft_cfg.sv
// Self-checking bench for fifo_fwft_cfg: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_fifo_fwft_cfg;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 18;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                push, pop, flush, err_clr;
    logic [WIDTH-1:0]    din;
    logic [WIDTH-1:0]    dout;
    logic [CNT_BITS-1:0] afull_th, aempty_th;
    logic                empty, full, afull, aempty, ovf, udf;
    logic [CNT_BITS-1:0] word_counter, peak;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_ovf, m_udf;
    int               m_peak;

    fifo_fwft_cfg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(din),
        .pop(pop),
        .dout(dout),
        .flush(flush),
        .afull_th(afull_th),
        .aempty_th(aempty_th),
        .err_clr(err_clr),
        .empty(empty),
        .full(full),
        .afull(afull),
        .aempty(aempty),
        .word_counter(word_counter),
        .ovf(ovf),
        .udf(udf),
        .peak(peak)
    );

    always #5 clk = ~clk;

    logic [15:0] act_status;
    assign act_status = {empty, full, afull, aempty, word_counter, ovf, udf, peak};

    // {empty, full, afull, aempty, count, ovf, udf, peak} from the model
    function automatic logic [15:0] exp_status();
        int n;
        logic [15:0] s;
        n = q.size();
        s = {n == 0, n == DEPTH, n >= int'(afull_th), n <= int'(aempty_th),
             CNT_BITS'(n), m_ovf, m_udf, CNT_BITS'(m_peak)};
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_peak = 0;
    endtask

    // Drive one cycle, advance the model at the edge, return 1 time unit after the edge.
    task automatic cycle(input logic pu, input logic [WIDTH-1:0] d, input logic po,
                         input logic fl, input logic ec);
        bit ev_o, ev_u, pa, pw;
        int n;
        push = pu; din = d; pop = po; flush = fl; err_clr = ec;
        @(posedge clk);
        n = q.size();
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            pa   = po && (n > 0);
            pw   = pu && ((n < DEPTH) || pa);
            ev_o = pu && !pw;
            ev_u = po && (n == 0);
            if (pa) void'(q.pop_front());
            if (pw) q.push_back(d);
        end
        if (ec) begin
            m_ovf  = ev_o;
            m_udf  = ev_u;
            m_peak = q.size();
        end else begin
            m_ovf = m_ovf | ev_o;
            m_udf = m_udf | ev_u;
            if (q.size() > m_peak) m_peak = q.size();
        end
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 0; pop = 0; flush = 0; err_clr = 0; din = '0;
        afull_th = 5'd12; aempty_th = 5'd3;
        model_reset();
        #2;
        checks++;
        if (act_status !== 16'b1001_00000_00_00000) begin
            failures++;
            $display("FAIL reset_status: got %b expected %b", act_status, 16'b1001_00000_00_00000);
        end
        afull_th = '0;
        #1;
        checks++;
        if (afull !== 1'b1) begin
            failures++;
            $display("FAIL reset_afull_th0: got %b expected 1", afull);
        end
        afull_th = 5'd12;
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 8'h00, 0, 0, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 8'(i), 0, 0, 0);
            checks++;
            if (act_status !== exp_status()) begin
                failures++;
                $display("FAIL fill_status[%0d]: got %b expected %b", i, act_status, exp_status());
            end
        end
        checks++;
        if (full !== 1'b1 || word_counter !== 5'd18 || peak !== 5'd18) begin
            failures++;
            $display("FAIL fill_full: full=%b cnt=%0d peak=%0d expected 1/18/18",
                     full, word_counter, peak);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== 8'(i)) begin
                failures++;
                $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, 8'(i));
            end
            cycle(0, 8'h00, 1, 0, 0);
        end
        checks++;
        if (empty !== 1'b1 || word_counter !== 5'd0) begin
            failures++;
            $display("FAIL drain_empty: empty=%b cnt=%0d expected 1/0", empty, word_counter);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0, 0);
        cycle(1, 8'hAA, 0, 0, 0);
        checks++;
        if (ovf !== 1'b1 || word_counter !== 5'd18 || act_status !== exp_status()) begin
            failures++;
            $display("FAIL ovf_set: got %b expected %b", act_status, exp_status());
        end
        cycle(0, 8'h00, 0, 0, 1);
        checks++;
        if (ovf !== 1'b0 || peak !== 5'd18) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b peak=%0d expected 0/18", ovf, peak);
        end
        cycle(1, 8'h77, 1, 0, 0);
        checks++;
        if (word_counter !== 5'd18 || ovf !== 1'b0 || act_status !== exp_status()) begin
            failures++;
            $display("FAIL full_push_pop: got %b expected %b", act_status, exp_status());
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== q[0]) begin
                failures++;
                $display("FAIL full_drain_dout[%0d]: got %h expected %h", i, dout, q[0]);
            end
            cycle(0, 8'h00, 1, 0, 0);
        end
    endtask

    task automatic test_underflow();
        cycle(1, 8'h5C, 1, 0, 0);
        checks++;
        if (word_counter !== 5'd1 || udf !== 1'b1 || dout !== 8'h5C) begin
            failures++;
            $display("FAIL empty_push_pop: cnt=%0d udf=%b dout=%h expected 1/1/5c",
                     word_counter, udf, dout);
        end
        cycle(0, 8'h00, 1, 0, 1);
        checks++;
        if (act_status !== exp_status() || udf !== 1'b0) begin
            failures++;
            $display("FAIL udf_clear: got %b expected %b", act_status, exp_status());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dout !== q[0] || act_status !== exp_status() || word_counter !== 5'd5) begin
                failures++;
                $display("FAIL wrap[%0d]: dout=%h exp %h status=%b exp %b",
                         i, dout, q[0], act_status, exp_status());
            end
            cycle(1, 8'($urandom), 1, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dout !== q[0]) begin
                failures++;
                $display("FAIL wrap_drain[%0d]: got %h expected %h", i, dout, q[0]);
            end
            cycle(0, 8'h00, 1, 0, 0);
        end
    endtask

    task automatic test_thresholds();
        afull_th = 5'd12; aempty_th = 5'd3;
        for (int i = 1; i <= 13; i++) begin
            cycle(1, 8'($urandom), 0, 0, 0);
            checks++;
            if (aempty !== (i <= 3) || afull !== (i >= 12)) begin
                failures++;
                $display("FAIL thresh[%0d]: aempty=%b afull=%b expected %b/%b",
                         i, aempty, afull, i <= 3, i >= 12);
            end
        end
        afull_th = 5'd14;
        #1;
        checks++;
        if (afull !== 1'b0) begin
            failures++;
            $display("FAIL thresh_change: afull=%b expected 0", afull);
        end
        aempty_th = 5'd20;
        #1;
        checks++;
        if (aempty !== 1'b1) begin
            failures++;
            $display("FAIL aempty_th_big: aempty=%b expected 1", aempty);
        end
        aempty_th = 5'd3;
    endtask

    task automatic test_flush();
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 7; i++) cycle(1, 8'($urandom), 0, 0, 0);
        cycle(1, 8'hEE, 0, 1, 0);
        checks++;
        if (word_counter !== 5'd0 || empty !== 1'b1 || peak !== 5'd7 ||
            act_status !== exp_status()) begin
            failures++;
            $display("FAIL flush: got %b expected %b (peak 7)", act_status, exp_status());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                afull_th  = CNT_BITS'($urandom_range(0, DEPTH + 1));
                aempty_th = CNT_BITS'($urandom_range(0, DEPTH + 1));
            end
            cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
            checks++;
            if (act_status !== exp_status() || (q.size() > 0 && dout !== q[0])) begin
                failures++;
                $display("FAIL random[%0d]: status=%b exp %b dout=%h", i, act_status,
                         exp_status(), dout);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), i == 2, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (act_status !== exp_status()) begin
            failures++;
            $display("FAIL async_reset: got %b expected %b", act_status, exp_status());
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 8'h3C, 0, 0, 0);
        checks++;
        if (act_status !== exp_status() || dout !== 8'h3C) begin
            failures++;
            $display("FAIL post_reset: status=%b exp %b dout=%h exp 3c",
                     act_status, exp_status(), dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_thresholds();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_fwft_cfg.md
# fifo_fwft_cfg

Parametrised first-word-fall-through FIFO, the next-generation replacement for the fixed-threshold FWFT FIFO used in the RSP stage-2 datapath. It adds arbitrary (non-power-of-two) depth, runtime-programmable almost-full/almost-empty thresholds, synchronous flush, sticky overflow/underflow error flags and a peak-occupancy watermark. It sits between stage producers and consumers wherever back-pressure must be tuned without resynthesis.

## Interface
- WIDTH, 128, data word width in bits (>=1)
- DEPTH, 18, number of storage entries (>=2, any integer)
- CNT_BITS, $clog2(DEPTH+1), width of occupancy-related ports

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- push  in  1  write request
- din  in  WIDTH  write data
- pop  in  1  read acknowledge of current dout
- dout  out  WIDTH  head word, valid whenever empty=0
- flush  in  1  synchronous clear of contents
- afull_th  in  CNT_BITS  almost-full threshold
- aempty_th  in  CNT_BITS  almost-empty threshold
- err_clr  in  1  clears ovf, udf, peak
- empty  out  1  count==0
- full  out  1  count==DEPTH
- afull  out  1  count>=afull_th
- aempty  out  1  count<=aempty_th
- word_counter  out  CNT_BITS  current occupancy
- ovf  out  1  sticky: push seen while full and not popped
- udf  out  1  sticky: pop seen while empty
- peak  out  CNT_BITS  max occupancy since reset/err_clr

## Operation
- Storage: DEPTH x WIDTH register array; write pointer wp, read pointer rp, each 0..DEPTH-1, wrap DEPTH-1 -> 0 (explicit compare, not modulo-2^n).
- Accepted push = push & (!full | pop_acc); accepted pop = pop_acc = pop & !empty.
- Per cycle, flush=0: count_next = count + push_acc - pop_acc; pointers advance on respective accept.
- push while full with pop=1: both accepted, count unchanged.
- push while full with pop=0: word dropped, ovf<=1.
- pop while empty: ignored, udf<=1; a simultaneous push is accepted normally (count 0->1).
- flush=1: wp, rp, count <=0 next edge; push/pop that cycle ignored, no ovf/udf set; ovf, udf, peak unaffected.
- err_clr=1: ovf, udf <=0, peak <= count_next; an error event in the same cycle wins (flag set).
- peak <= max(peak, count_next) every cycle.
- Status flags are combinational compares on registered count; thresholds may change any cycle and take effect immediately.
- afull_th=0 forces afull=1; aempty_th>=DEPTH forces aempty=1. No clamping.
- dout = mem[rp], combinational mux from registers; undefined content while empty (bench must not check).

## Timing
- Reset (rst=1, async): wp=rp=count=0, ovf=udf=0, peak=0; therefore empty=1, full=0, word_counter=0, aempty=1 (aempty_th>=0), afull per afull_th (1 only if afull_th=0).
- Write-to-read latency 1: push at edge N -> empty=0 and dout=din valid after edge N.
- Pop at edge N -> dout shows next word after edge N; no bubble on back-to-back pops.
- Flags and word_counter update on the same edge as the accepted transfer; no extra pipeline.
- Full sustained throughput: one push and one pop per cycle at any occupancy including 0 (push only) and DEPTH.
- Reset deasserted mid-stream: first edge after release behaves as empty FIFO; outputs glitch-free derived from registers.

## Test plan
- DEPTH=18, WIDTH=8: push 0x00..0x11 (18 words) -> full=1 at word_counter=18, peak=18; pop 18 -> dout sequence 0x00..0x11, empty=1 after last.
- Full + push without pop: push 0xAA at count=18 -> word dropped, ovf=1, count=18; err_clr -> ovf=0, peak=18.
- Simultaneous push/pop at full and at empty: at 18 count stays 18, ovf=0; at 0 with pop+push 0x5C -> count=1, udf=1, dout=0x5C next cycle.
- Wrap-around: 40 cycles of streaming push/pop at steady count 5 -> pointers wrap twice, data order preserved, no flag change.
- Thresholds: afull_th=12, aempty_th=3; fill 0->13 -> aempty drops at count 4, afull rises at count 12; change afull_th to 14 at count 13 -> afull=0 same cycle.
- Flush with push in same cycle at count 7 -> count=0, empty=1, ovf/udf unchanged, peak=7; async rst mid-stream -> all outputs reset values immediately.
